// File: rtl/quickq_cmd_frontend.sv
// QuickQ command front-end: buffers router requests in a FIFO and
// issues them one at a time to the QuickQ control FSM.
module quickq_cmd_frontend #(
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 4,
  parameter int CAP     = 16,
  parameter int TIMEOUT = 255
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic                       s_op,
  input  logic [DATA_W-1:0]          s_data,
  output logic                       enq,
  output logic                       deq,
  output logic [DATA_W-1:0]          enq_data,
  input  logic                       done,
  input  logic [DATA_W-1:0]          deq_data,
  output logic                       r_valid,
  input  logic                       r_ready,
  output logic [DATA_W-1:0]          r_data,
  output logic [1:0]                 r_err,
  output logic [$clog2(CAP+1)-1:0]   count,
  output logic [$clog2(DEPTH+1)-1:0] fifo_level
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW = $clog2(DEPTH+1);
  localparam int CW = $clog2(CAP+1);
  localparam int TW = $clog2(TIMEOUT+1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t state, state_nx;

  logic [DATA_W:0]   mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [LW-1:0]     level;
  logic [DATA_W:0]   head;
  logic              push, pop;
  logic              head_op;
  logic              under, over;
  logic              cmd_op;
  logic [DATA_W-1:0] cmd_data;
  logic [TW-1:0]     tcnt;
  logic              expired;

  assign s_ready    = (level != LW'(DEPTH));
  assign fifo_level = level;
  assign push       = s_valid & s_ready;
  assign pop        = (state == IDLE) && (level != '0);
  assign head       = mem[rd_ptr];
  assign head_op    = head[DATA_W];
  assign under      = head_op && (count == '0);
  assign over       = !head_op && (count == CW'(CAP));
  assign expired    = (tcnt == TW'(TIMEOUT-1));
  assign enq_data   = cmd_data;

  // FIFO storage; entries are {op, data}
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {s_op, s_data};
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      level <= level + LW'(push) - LW'(pop);
    end
  end

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (pop) begin
          if (under || over) state_nx = RESP;
          else               state_nx = ISSUE;
        end
      end
      ISSUE: state_nx = WAIT;
      WAIT: begin
        if (done || expired) state_nx = RESP;
      end
      RESP: begin
        if (r_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // output decode
  always_comb begin
    enq     = 1'b0;
    deq     = 1'b0;
    r_valid = 1'b0;
    unique case (state)
      ISSUE: begin
        enq = !cmd_op;
        deq = cmd_op;
      end
      RESP:    r_valid = 1'b1;
      default: ;
    endcase
  end

  // command register, occupancy, timeout counter and response fields
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_op   <= 1'b0;
      cmd_data <= '0;
      tcnt     <= '0;
      count    <= '0;
      r_data   <= '0;
      r_err    <= 2'b00;
    end else begin
      unique case (state)
        IDLE: begin
          if (pop) begin
            cmd_op   <= head_op;
            cmd_data <= head[DATA_W-1:0];
            tcnt     <= '0;
            r_data   <= '0;
            if (under)     r_err <= 2'b01;
            else if (over) r_err <= 2'b10;
            else           r_err <= 2'b00;
          end
        end
        WAIT: begin
          if (done) begin
            r_err <= 2'b00;
            if (cmd_op) begin
              count  <= count - CW'(1);
              r_data <= deq_data;
            end else begin
              count  <= count + CW'(1);
              r_data <= '0;
            end
          end else begin
            tcnt <= tcnt + TW'(1);
            if (expired) begin
              r_err  <= 2'b11;
              r_data <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_quickq_cmd_frontend.sv
// Self-checking bench for quickq_cmd_frontend.
// Queue contents are modelled directly; count is the model's size.
module tb_quickq_cmd_frontend;

  localparam int DW  = 32;
  localparam int DEP = 4;
  localparam int CAP = 4;
  localparam int TO  = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          s_valid, s_ready, s_op;
  logic [DW-1:0] s_data;
  logic          enq, deq;
  logic [DW-1:0] enq_data;
  logic          done;
  logic [DW-1:0] deq_data;
  logic          r_valid, r_ready;
  logic [DW-1:0] r_data;
  logic [1:0]    r_err;
  logic [2:0]    count;
  logic [2:0]    fifo_level;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] mq [$];
  logic [DW-1:0] bd [6];

  quickq_cmd_frontend #(
    .DATA_W(DW), .DEPTH(DEP), .CAP(CAP), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready),
    .s_op(s_op), .s_data(s_data),
    .enq(enq), .deq(deq), .enq_data(enq_data),
    .done(done), .deq_data(deq_data),
    .r_valid(r_valid), .r_ready(r_ready),
    .r_data(r_data), .r_err(r_err),
    .count(count), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_s_ready"}, 32'(s_ready), 32'd1);
    chk({tag, "_level"}, 32'(fifo_level), 32'd0);
    chk({tag, "_count"}, 32'(count), 32'd0);
    chk({tag, "_enq"}, 32'(enq), 32'd0);
    chk({tag, "_deq"}, 32'(deq), 32'd0);
    chk({tag, "_enq_data"}, enq_data, 32'd0);
    chk({tag, "_r_valid"}, 32'(r_valid), 32'd0);
    chk({tag, "_r_data"}, r_data, 32'd0);
    chk({tag, "_r_err"}, 32'(r_err), 32'd0);
  endtask

  // called at the negedge where r_valid is first seen
  task automatic finish_resp(input logic [31:0] e_data, input int e_err,
                             input int stall);
    chk("resp_err", 32'(r_err), 32'(e_err));
    chk("resp_data", r_data, e_data);
    chk("resp_count", 32'(count), 32'(mq.size()));
    for (int i = 0; i < stall; i++) begin
      r_ready = 1'b0;
      done = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("stall_valid", 32'(r_valid), 32'd1);
      chk("stall_data", r_data, e_data);
      chk("stall_err", 32'(r_err), 32'(e_err));
      chk("stall_count", 32'(count), 32'(mq.size()));
    end
    done = 1'b0;
    r_ready = 1'b1;
    @(negedge clk);
    r_ready = 1'b0;
    chk("rvalid_drop", 32'(r_valid), 32'd0);
  endtask

  // starts at a negedge in IDLE with this command at the FIFO head;
  // dly = WAIT cycles before done, negative = never
  task automatic serve(input logic op, input logic [31:0] d,
                       input int dly, input int stall);
    int e_err;
    logic [31:0] e_data;
    int pulses, n;
    bit got;
    bit issued;
    e_err = 0;
    if (op && mq.size() == 0)        e_err = 1;
    else if (!op && mq.size() == CAP) e_err = 2;
    else if (dly < 0)                e_err = 3;
    issued = (e_err == 0 || e_err == 3);
    e_data = (op && e_err == 0) ? mq[0] : 32'h0;
    @(negedge clk);
    chk("lat_rvalid", 32'(r_valid), 32'(!issued));
    chk("lat_enq", 32'(enq), 32'(!op && issued));
    chk("lat_deq", 32'(deq), 32'(op && issued));
    if (!op && issued) chk("enq_data", enq_data, d);
    pulses = 0;
    n = 0;
    got = r_valid;
    while (!got && n < 40) begin
      done = (dly >= 0 && n == dly + 1);
      deq_data = op ? e_data : $urandom;
      @(negedge clk);
      n++;
      done = 1'b0;
      if (!op && r_valid == 1'b0 && n <= dly)
        chk("enq_data_hold", enq_data, d);
      if (enq || deq) pulses++;
      got = r_valid;
    end
    if (issued) begin
      chk("resp_seen", 32'(got), 32'd1);
      chk("extra_pulses", 32'(pulses), 32'd0);
      chk("resp_lat", 32'(n), 32'(e_err == 3 ? TO + 1 : dly + 2));
    end
    if (e_err == 0) begin
      if (op) void'(mq.pop_front());
      else    mq.push_back(d);
    end
    finish_resp(e_data, e_err, stall);
  endtask

  // push into an empty FIFO from IDLE, then serve it
  task automatic run_cmd(input logic op, input logic [31:0] d,
                         input int dly, input int stall);
    @(negedge clk);
    s_valid = 1'b1;
    s_op = op;
    s_data = d;
    @(negedge clk);
    s_valid = 1'b0;
    chk("push_level", 32'(fifo_level), 32'd1);
    serve(op, d, dly, stall);
  endtask

  initial begin
    int acc, pi, n, r, dly;
    bit seen;
    rst = 1'b1;
    s_valid = 1'b0; s_op = 1'b0; s_data = '0;
    done = 1'b0; deq_data = '0; r_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset("rst");
    rst = 1'b0;

    run_cmd(1'b0, 32'h5, 3, 1);
    run_cmd(1'b1, 32'h0, 2, 0);
    run_cmd(1'b1, 32'h0, 1, 0);
    for (int i = 0; i < 5; i++)
      run_cmd(1'b0, $urandom, int'($urandom_range(0, 7)), 0);
    run_cmd(1'b0, 32'hAB, 7, 5);

    for (int i = 0; i < 24; i++) begin
      r = int'($urandom_range(0, 9));
      dly = (r > 7) ? -1 : r;
      run_cmd(1'($urandom_range(0, 1)), $urandom, dly,
              int'($urandom_range(0, 3)));
    end

    while (mq.size() > 0)
      run_cmd(1'b1, 32'h0, int'($urandom_range(0, 3)), 0);

    for (int i = 0; i < 6; i++) bd[i] = $urandom;
    acc = 0;
    pi = -1;
    for (int i = 0; i < 6; i++) begin
      s_valid = 1'b1;
      s_op = 1'b0;
      s_data = bd[acc];
      if (s_ready) acc++;
      @(negedge clk);
      if (enq) pi = i;
    end
    s_valid = 1'b0;
    chk("burst_acc", 32'(acc), 32'd5);
    chk("burst_level", 32'(fifo_level), 32'd4);
    chk("burst_ready", 32'(s_ready), 32'd0);
    chk("burst_pulse", 32'(pi), 32'd1);
    n = 0;
    while (!r_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("burst_to_lat", 32'(n), 32'(TO - 3));
    finish_resp(32'h0, 3, 2);
    for (int i = 1; i < 5; i++)
      serve(1'b0, bd[i], int'($urandom_range(0, 7)), 0);
    chk("burst_count", 32'(count), 32'd4);

    @(negedge clk);
    s_valid = 1'b1;
    s_op = 1'b1;
    s_data = 32'h77;
    @(negedge clk);
    s_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    mq.delete();
    chk_reset("midwait");
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      done = ~done;
      deq_data = $urandom;
      @(negedge clk);
      if (r_valid) seen = 1'b1;
    end
    done = 1'b0;
    chk("midwait_noresp", 32'(seen), 32'd0);
    chk("midwait_count", 32'(count), 32'd0);

    run_cmd(1'b0, 32'h1234, 0, 0);
    run_cmd(1'b1, 32'h0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/quickq_cmd_frontend.md
Name: quickq_cmd_frontend

Overview:
- Command front-end sitting directly upstream of the QuickQ control FSM.
- Accepts enqueue/dequeue requests from the router side over a valid/ready handshake and buffers them in a small FIFO.
- Issues one command at a time to the control FSM as a single-cycle enq/deq pulse, waits for done, then returns one response per command.
- Tracks queue occupancy and rejects underflow and overflow requests locally, without issuing them to the core.

Parameters:
- DATA_W, 32: width of queue entries.
- DEPTH, 4: command FIFO depth; power of 2, minimum 2.
- CAP, 16: total QuickQ capacity in entries.
- TIMEOUT, 255: maximum WAIT cycles before the command is aborted.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- s_valid  in  1  request valid
- s_ready  out  1  request accepted when s_valid&s_ready; equals !fifo_full
- s_op  in  1  0=enqueue, 1=dequeue
- s_data  in  DATA_W  enqueue value (ignored for dequeue)
- enq  out  1  one-cycle enqueue strobe to control FSM
- deq  out  1  one-cycle dequeue strobe to control FSM
- enq_data  out  DATA_W  value accompanying enq; held stable from ISSUE through WAIT
- done  in  1  operation complete from control FSM; sampled only in WAIT
- deq_data  in  DATA_W  dequeued value, valid in the cycle done=1
- r_valid  out  1  response valid
- r_ready  in  1  response accepted when r_valid&r_ready
- r_data  out  DATA_W  dequeued value; 0 for enqueue and error responses
- r_err  out  2  00 ok, 01 underflow, 10 overflow, 11 timeout
- count  out  $clog2(CAP+1)  current queue occupancy
- fifo_level  out  $clog2(DEPTH+1)  buffered commands

Behaviour:
- Reset is rst, synchronous, active-high; clock is clk. Values after reset:
  - FIFO emptied; fifo_level=0; s_ready=1; count=0.
  - enq=0, deq=0, enq_data=0, r_valid=0, r_data=0, r_err=0; state=IDLE.
- Reset asserted in any state, including mid-WAIT, aborts the in-flight command. No response is produced and count is not updated.
- FIFO:
  - Entry is {op, data}. Push on s_valid&s_ready.
  - s_ready depends only on registered level, so there is no push when full, even if a pop occurs in the same cycle.
  - Simultaneous push and pop (not full) leaves fifo_level unchanged.
  - Pointers wrap modulo DEPTH.
- FSM states IDLE, ISSUE, WAIT, RESP:
  - IDLE: if FIFO non-empty, pop the head into the command register. Then:
    - deq with count==0 -> RESP with r_err=01.
    - enq with count==CAP -> RESP with r_err=10.
    - otherwise -> ISSUE. Clear the timeout counter.
  - ISSUE: exactly one cycle. enq=1 (enq_data=cmd data) or deq=1. Next state WAIT.
  - WAIT: enq=deq=0.
    - On done=1: enq increments count; deq decrements count and captures deq_data into r_data. r_err=00 -> RESP.
    - Otherwise the timeout counter increments. On reaching TIMEOUT: r_err=11, count unchanged -> RESP.
  - RESP: r_valid=1, with r_data/r_err stable until r_valid&r_ready. On acceptance -> IDLE and r_valid=0 next cycle.
- Latency: a request pushed at edge T0 gives:
  - pop at T1;
  - enq/deq high in cycle T1..T2;
  - for errors, r_valid high from T1.
  - Minimum ok response: r_valid rises the cycle after done is sampled.
- Exactly one command in flight. No new pop while in ISSUE, WAIT or RESP. The FIFO keeps accepting while space remains.
- done outside WAIT is ignored. count never exceeds CAP and never goes below 0.

Test Plan:
- Enq 0x0000_0005; core returns done 4 cycles after enq pulse:
  - enq pulse exactly 1 cycle with enq_data=5;
  - response r_err=00, r_data=0; count=1.
- After the above, deq with deq_data=0x5 at done:
  - deq pulse 1 cycle; r_data=0x5, r_err=00; count=0.
- Deq on empty queue:
  - no deq pulse; r_valid at T1 with r_err=01; count stays 0.
- CAP=4, five enqs each completed by done:
  - first four r_err=00; fifth gets r_err=10 with no enq pulse; count=4.
- done withheld, DEPTH=4, six back-to-back requests:
  - one command in WAIT plus 4 buffered; s_ready=0 with fifo_level=4;
  - after TIMEOUT=8 cycles in WAIT the response has r_err=11 and count is unchanged.
- Assert rst mid-WAIT, and separately hold r_ready=0 for 5 cycles in RESP:
  - rst: all outputs return to reset values and no response is produced;
  - r_ready held low: r_valid, r_data and r_err remain stable until the handshake.
